hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter DATA_WIDTH, default 32, register data width.
REQ-002 Parameter REGADDR_WIDTH, default 5, register address width.
REQ-003 Parameter DEPTH, default 3, number of in-flight slots after issue, legal range 1..16.
REQ-004 Parameter CNT_WIDTH, default 16, width of the hazard counter.
REQ-005 Port clk, input, 1, single clock; all state changes on the rising edge.
REQ-006 Port rst, input, 1, reset, asynchronous and active-high.
REQ-007 Port issue_valid, input, 1, an instruction is presented for issue.
REQ-008 Port issue_src1 and issue_src2, input, REGADDR_WIDTH each, source register addresses.
REQ-009 Port issue_dst, input, REGADDR_WIDTH, destination register; 0 means no write.
REQ-010 Port issue_kill, input, 1, the presented instruction is squashed (branch) and inserted as a bubble.
REQ-011 Port ext_stall, input, 1, downstream stall (memory busy); freezes all slots.
REQ-012 Port res_valid, input, 1, a result is delivered this cycle.
REQ-013 Port res_slot, input, max(1,$clog2(DEPTH)), index of the slot whose result is delivered.
REQ-014 Port res_data, input, DATA_WIDTH, the result value.
REQ-015 Port src1_hit/src2_hit, output, 1 each, the operand is forwarded from a slot.
REQ-016 Port src1_data/src2_data, output, DATA_WIDTH each, the forwarded value; 0 when there is no hit.
REQ-017 Port hazard_stall, output, 1, the issue is blocked by an unresolved producer.
REQ-018 Port issue_accept, output, 1, the issue is taken this cycle.
REQ-019 Port hazard_cnt, output, CNT_WIDTH, count of hazard bubbles inserted.

Function
REQ-020 Each slot SHALL hold vld, dst, rdy and data; slot 0 is the youngest and slot DEPTH-1 the oldest.
REQ-021 Lookup for each source SHALL be combinational from slot state and the res_* inputs.
REQ-022 Lookup SHALL select the lowest-index slot with vld=1, dst equal to the source address, and source address not 0.
REQ-023 A source of 0 SHALL never produce a hit or a hazard.
REQ-024 The selected slot SHALL give a hit with its data when rdy=1.
REQ-025 The selected slot SHALL give a hit with res_data when rdy=0 and res_valid=1 and res_slot equals that slot (same-cycle bypass).
REQ-026 The selected slot SHALL raise a hazard in all other rdy=0 cases.
REQ-027 A younger unready match SHALL shadow any older ready match.
REQ-028 hazard_stall SHALL equal issue_valid AND NOT issue_kill AND a hazard on either source.
REQ-029 issue_accept SHALL equal issue_valid AND NOT hazard_stall AND NOT ext_stall.
REQ-030 Advance (ext_stall=0) SHALL shift slot i into slot i+1; slot DEPTH-1 retires and is discarded.
REQ-031 On advance, slot 0 SHALL load {vld=1, dst=issue_dst, rdy=0} only if issue_accept=1, issue_kill=0 and issue_dst is not 0; otherwise it loads a bubble (vld=0).
REQ-032 Hold (ext_stall=1) SHALL leave all slots unchanged except for result capture.
REQ-033 A result with res_valid=1 and res_slot < DEPTH targeting a valid slot SHALL set rdy=1 and data=res_data in that entry, travelling with the entry: to res_slot+1 on advance, in place on hold.
REQ-034 A result captured for slot DEPTH-1 during an advance SHALL be dropped, because the entry retires.
REQ-035 A result with res_slot >= DEPTH, or targeting a slot with vld=0, SHALL be ignored.
REQ-036 hazard_cnt SHALL increment by 1, wrapping modulo 2^CNT_WIDTH, on each edge where hazard_stall=1 and ext_stall=0.

Reset
REQ-037 While rst=1, all slots SHALL have vld=0, rdy=0, dst=0 and data=0, and hazard_cnt SHALL be 0, asynchronously.
REQ-038 After rst=1, with inputs idle, all outputs SHALL be 0.
REQ-039 Assertion of rst mid-operation SHALL discard all in-flight entries and results immediately.
REQ-040 The first edge after rst deasserts SHALL behave as a normal cycle.

Verification
REQ-041 Reset test: assert rst mid-pipeline, then lookup r3 -> src1_hit=0, hazard_stall=0, hazard_cnt=0.
REQ-042 Forward test: issue dst=3; next cycle res_valid, res_slot=0, res_data=0xDEADBEEF; next cycle issue src1=3 -> src1_hit=1, src1_data=0xDEADBEEF, issue_accept=1.
REQ-043 Load-use test: issue dst=4 with no result; next cycle issue src2=4 -> hazard_stall=1 and a bubble is inserted, hazard_cnt=1; next cycle res_slot=1, res_data=0x55 -> src2_hit=1, src2_data=0x55, hazard_stall=0, issue_accept=1.
REQ-044 Priority test: r5 in slot 2 ready with 0x11 and in slot 0 ready with 0x22; issue src1=5 -> src1_data=0x22; with slot 0 unready instead -> hazard_stall=1.
REQ-045 Zero and kill test: issue dst=0, then src1=0 -> no hit, no stall; issue_kill with a hazardous source -> hazard_stall=0 and slot 0 gets a bubble.
REQ-046 Stall and retire test: ext_stall=1 for 3 cycles -> slots frozen, hazard_cnt unchanged; DEPTH=3 entry after 3 advances -> no longer hits.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// In-flight destination scoreboard with operand forwarding and
// load-use hazard detection for an in-order issue stage.
module hazard_scoreboard #(
  parameter int DATA_WIDTH    = 32,
  parameter int REGADDR_WIDTH = 5,
  parameter int DEPTH         = 3,
  parameter int CNT_WIDTH     = 16,
  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [REGADDR_WIDTH-1:0] issue_src1,
  input  logic [REGADDR_WIDTH-1:0] issue_src2,
  input  logic [REGADDR_WIDTH-1:0] issue_dst,
  input  logic                     issue_kill,
  input  logic                     ext_stall,
  input  logic                     res_valid,
  input  logic [SW-1:0]            res_slot,
  input  logic [DATA_WIDTH-1:0]    res_data,
  output logic                     src1_hit,
  output logic                     src2_hit,
  output logic [DATA_WIDTH-1:0]    src1_data,
  output logic [DATA_WIDTH-1:0]    src2_data,
  output logic                     hazard_stall,
  output logic                     issue_accept,
  output logic [CNT_WIDTH-1:0]     hazard_cnt
);

  localparam int LW = DATA_WIDTH + 2;

  logic [DEPTH-1:0]                    vld_q, vld_d;
  logic [DEPTH-1:0]                    rdy_q, rdy_d;
  logic [DEPTH-1:0][REGADDR_WIDTH-1:0] dst_q, dst_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]    data_q, data_d;
  logic [CNT_WIDTH-1:0]                cnt_q, cnt_d;

  logic [DEPTH-1:0]                    rdy_c;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]    data_c;

  logic          res_ok;
  logic [LW-1:0] lk1, lk2;
  logic          haz1, haz2;
  logic          push;

  assign res_ok = res_valid && (32'(res_slot) < 32'(DEPTH));

  // Returns {hit, hazard, data}; the youngest match wins, so a scan
  // from oldest to youngest lets later assignments override.
  function automatic logic [LW-1:0] lookup(
    input logic [REGADDR_WIDTH-1:0] src
  );
    logic                  found;
    logic                  rdy;
    logic                  byp;
    logic [DATA_WIDTH-1:0] dat;
    logic                  hit;
    found = 1'b0;
    rdy   = 1'b0;
    byp   = 1'b0;
    dat   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vld_q[i] && dst_q[i] == src && src != '0) begin
        found = 1'b1;
        rdy   = rdy_q[i];
        dat   = data_q[i];
        byp   = res_ok && (res_slot == SW'(i));
      end
    end
    hit = found && (rdy || byp);
    if (!hit)
      dat = '0;
    else if (!rdy)
      dat = res_data;
    return {hit, found && !rdy && !byp, dat};
  endfunction

  always_comb begin
    lk1 = lookup(issue_src1);
    lk2 = lookup(issue_src2);
  end

  assign src1_hit  = lk1[LW-1];
  assign haz1      = lk1[LW-2];
  assign src1_data = lk1[DATA_WIDTH-1:0];
  assign src2_hit  = lk2[LW-1];
  assign haz2      = lk2[LW-2];
  assign src2_data = lk2[DATA_WIDTH-1:0];

  assign hazard_stall = issue_valid && !issue_kill && (haz1 || haz2);
  assign issue_accept = issue_valid && !hazard_stall && !ext_stall;
  assign push = issue_accept && !issue_kill && (issue_dst != '0);
  assign hazard_cnt = cnt_q;

  always_comb begin
    rdy_c  = rdy_q;
    data_c = data_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (res_ok && res_slot == SW'(i) && vld_q[i]) begin
        rdy_c[i]  = 1'b1;
        data_c[i] = res_data;
      end
    end
  end

  always_comb begin
    vld_d  = vld_q;
    rdy_d  = rdy_c;
    dst_d  = dst_q;
    data_d = data_c;
    cnt_d  = cnt_q;
    if (!ext_stall) begin
      for (int i = 1; i < DEPTH; i++) begin
        vld_d[i]  = vld_q[i-1];
        rdy_d[i]  = rdy_c[i-1];
        dst_d[i]  = dst_q[i-1];
        data_d[i] = data_c[i-1];
      end
      vld_d[0]  = push;
      rdy_d[0]  = 1'b0;
      dst_d[0]  = push ? issue_dst : '0;
      data_d[0] = '0;
      if (hazard_stall)
        cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      rdy_q  <= '0;
      dst_q  <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      rdy_q  <= rdy_d;
      dst_q  <= dst_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding, load-use,
// priority, kill, stall, retire and reset behaviour at DEPTH=3.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_src1, issue_src2, issue_dst;
  logic        issue_kill;
  logic        ext_stall;
  logic        res_valid;
  logic [1:0]  res_slot;
  logic [31:0] res_data;
  logic        src1_hit, src2_hit;
  logic [31:0] src1_data, src2_data;
  logic        hazard_stall, issue_accept;
  logic [15:0] hazard_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid),
    .issue_src1(issue_src1),
    .issue_src2(issue_src2),
    .issue_dst(issue_dst),
    .issue_kill(issue_kill),
    .ext_stall(ext_stall),
    .res_valid(res_valid),
    .res_slot(res_slot),
    .res_data(res_data),
    .src1_hit(src1_hit),
    .src2_hit(src2_hit),
    .src1_data(src1_data),
    .src2_data(src2_data),
    .hazard_stall(hazard_stall),
    .issue_accept(issue_accept),
    .hazard_cnt(hazard_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 0; issue_src1 = 0; issue_src2 = 0;
    issue_dst = 0; issue_kill = 0; ext_stall = 0;
    res_valid = 0; res_slot = 0; res_data = 0;
  endtask

  task automatic issue(input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d);
    issue_valid = 1; issue_src1 = s1; issue_src2 = s2; issue_dst = d;
  endtask

  task automatic res(input logic [1:0] s, input logic [31:0] v);
    res_valid = 1; res_slot = s; res_data = v;
  endtask

  // Advance one edge, then set idle inputs and let them settle.
  task automatic step();
    @(posedge clk);
    #1 idle();
    #1;
  endtask

  initial begin
    idle();
    rst = 1;
    #2;
    chk("rst_hit1", 32'(src1_hit), 0);
    chk("rst_stall", 32'(hazard_stall), 0);
    chk("rst_acc", 32'(issue_accept), 0);
    chk("rst_cnt", 32'(hazard_cnt), 0);
    @(negedge clk);
    rst = 0;
    step();

    // forward
    issue(0, 0, 3); #1;
    chk("fwd_acc0", 32'(issue_accept), 1);
    step();
    res(0, 32'hDEADBEEF); #1;
    step();
    issue(3, 0, 0); #1;
    chk("fwd_hit", 32'(src1_hit), 1);
    chk("fwd_data", src1_data, 32'hDEADBEEF);
    chk("fwd_acc", 32'(issue_accept), 1);
    chk("fwd_nohit2", 32'(src2_hit), 0);
    step();

    // load-use
    issue(0, 0, 4); #1;
    step();
    issue(0, 4, 0); #1;
    chk("lu_stall", 32'(hazard_stall), 1);
    chk("lu_acc", 32'(issue_accept), 0);
    step();
    chk("lu_cnt", 32'(hazard_cnt), 1);
    issue(0, 4, 0); res(1, 32'h55); #1;
    chk("lu_hit", 32'(src2_hit), 1);
    chk("lu_data", src2_data, 32'h55);
    chk("lu_stall2", 32'(hazard_stall), 0);
    chk("lu_acc2", 32'(issue_accept), 1);
    step();
    chk("lu_cnt2", 32'(hazard_cnt), 1);

    // priority: r5 ready 0x11 in slot 2, younger r5 in slot 0
    issue(0, 0, 5); #1;
    step();
    res(0, 32'h11); #1;
    step();
    issue(0, 0, 5); #1;
    step();
    ext_stall = 1; issue(5, 0, 0); #1;
    chk("pri_shadow", 32'(hazard_stall), 1);
    chk("pri_acc", 32'(issue_accept), 0);
    res(0, 32'h22); #1;
    chk("pri_byp_hit", 32'(src1_hit), 1);
    chk("pri_byp", src1_data, 32'h22);
    chk("pri_byp_st", 32'(hazard_stall), 0);
    step();
    chk("pri_cnt", 32'(hazard_cnt), 1);
    ext_stall = 1; issue(5, 0, 0); #1;
    chk("pri_data", src1_data, 32'h22);
    chk("pri_acc_ext", 32'(issue_accept), 0);
    step();

    // stall 3 cycles: r5(0x22) in slot 0 stays frozen
    for (int k = 0; k < 3; k++) begin
      ext_stall = 1; issue(0, 5, 0); #1;
      step();
    end
    issue(0, 5, 0); #1;
    chk("stl_frozen", src2_data, 32'h22);
    chk("stl_cnt", 32'(hazard_cnt), 1);
    // three advances retire the entry
    step(); step();
    issue(5, 0, 0); #1;
    chk("ret_slot2", src1_data, 32'h22);
    step();
    issue(5, 0, 0); #1;
    chk("ret_gone", 32'(src1_hit), 0);
    chk("ret_nost", 32'(hazard_stall), 0);
    step();

    // zero and kill
    issue(0, 0, 0); #1;
    chk("z_acc", 32'(issue_accept), 1);
    step();
    issue(0, 0, 0); #1;
    chk("z_hit", 32'(src1_hit), 0);
    chk("z_stall", 32'(hazard_stall), 0);
    step();
    issue(0, 0, 7); #1;
    step();
    issue(7, 0, 8); issue_kill = 1; #1;
    chk("k_stall", 32'(hazard_stall), 0);
    step();
    issue(8, 7, 0); #1;
    chk("k_bubble", 32'(src1_hit), 0);
    chk("k_r7haz", 32'(hazard_stall), 1);
    step();
    chk("k_cnt", 32'(hazard_cnt), 2);

    // out-of-range result slot is ignored
    issue(0, 0, 9); #1;
    step();
    res(3, 32'h99); #1;
    step();
    issue(9, 0, 0); #1;
    chk("oor_haz", 32'(hazard_stall), 1);
    chk("oor_hit", 32'(src1_hit), 0);

    // asynchronous reset mid-pipeline
    rst = 1; #1;
    issue(3, 9, 0); #1;
    chk("mr_hit", 32'(src1_hit), 0);
    chk("mr_stall", 32'(hazard_stall), 0);
    chk("mr_cnt", 32'(hazard_cnt), 0);
    @(negedge clk);
    rst = 0;
    idle();
    issue(0, 0, 6); #1;
    chk("mr_acc", 32'(issue_accept), 1);
    step();
    issue(6, 0, 0); #1;
    chk("mr_first", 32'(hazard_stall), 1);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
